// File: rtl/cg_pkg.sv
// cg_pkg: shared types and constants for the clock-gating controller.
//   cg_state_e  : controller FSM state encoding
//   CG_STATS_W  : width of the optional gated-cycle statistics counter
package cg_pkg;

    typedef enum logic [2:0] {
        CG_RUN,
        CG_IDLE,
        CG_SREQ,
        CG_GATED,
        CG_WAKE
    } cg_state_e;

    localparam int CG_STATS_W = 32;

endpackage

// File: rtl/cg_idle_cnt.sv
// cg_idle_cnt: saturating idle-cycle counter with threshold compare.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (priority over inc)
//   inc        : increment, saturating at all-ones
//   thr        : threshold; 0 is treated as 1
//   at_thr     : registered count >= effective threshold
module cg_idle_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] thr,
    output logic             at_thr
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] thr_eff;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A zero threshold would otherwise request sleep without any idle cycle.
    assign thr_eff = (thr == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : thr;
    assign at_thr  = (cnt_reg >= thr_eff);

endmodule

// File: rtl/cg_ctrl.sv
// cg_ctrl: clock-gating controller driving the enable of one posedge ICG.
// Watches the domain for sustained idleness, runs a four-phase sleep
// handshake (slp_req/slp_ack), drops ck_en only after the acknowledge, and
// restores the clock on wake with a fixed settle delay before release.
// Ports:
//   clk, rst_n    : source clock (also feeds the ICG), async active-low reset
//   cfg_en        : gating permitted; 0 forces the clock on
//   cfg_idle_thr  : idle cycles required before a sleep request (0 acts as 1)
//   busy          : domain activity
//   wake_req      : level wake request
//   slp_ack       : domain acknowledge of slp_req
//   slp_req       : sleep request to the domain
//   ck_en         : ICG enable, registered
//   gated         : clock currently gated
//   wake_done     : one-cycle pulse on return to RUN after a wake
// Optional (macro CG_STATS_EN):
//   stats_clr     : synchronous clear of gated_cycles
//   gated_cycles  : saturating count of cycles with ck_en low
module cg_ctrl
    import cg_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [CNT_W-1:0]      cfg_idle_thr,
    input  logic                  busy,
    input  logic                  wake_req,
    input  logic                  slp_ack,
`ifdef CG_STATS_EN
    input  logic                  stats_clr,
    output logic [CG_STATS_W-1:0] gated_cycles,
`endif
    output logic                  slp_req,
    output logic                  ck_en,
    output logic                  gated,
    output logic                  wake_done
);

    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES);

    cg_state_e     state_reg;
    cg_state_e     state_next;
    logic [WW-1:0] wake_cnt_reg;
    logic [WW-1:0] wake_cnt_next;
    logic          idle;
    logic          at_thr;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          slp_req_next;
    logic          ck_en_next;
    logic          gated_next;
    logic          wake_done_next;

    assign idle = cfg_en & ~busy & ~wake_req;

    // The counter only runs while the FSM is (or stays) in IDLE, so the
    // RUN->IDLE transition naturally loads 1 from a cleared counter.
    assign cnt_inc = (state_next == CG_IDLE);
    assign cnt_clr = ~cnt_inc;

    cg_idle_cnt #(
        .CNT_W (CNT_W)
    ) u_idle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .thr    (cfg_idle_thr),
        .at_thr (at_thr)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CG_RUN;
            wake_cnt_reg <= '0;
            slp_req      <= 1'b0;
            ck_en        <= 1'b1;
            gated        <= 1'b0;
            wake_done    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wake_cnt_reg <= wake_cnt_next;
            slp_req      <= slp_req_next;
            ck_en        <= ck_en_next;
            gated        <= gated_next;
            wake_done    <= wake_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CG_RUN: begin
                // A lingering slp_ack from the last handshake blocks re-request.
                if (idle && !slp_ack) state_next = CG_IDLE;
            end
            CG_IDLE: begin
                if (!idle)       state_next = CG_RUN;
                else if (at_thr) state_next = CG_SREQ;
            end
            CG_SREQ: begin
                // Ack racing a loss of idle: wake, never gate.
                if (!idle)        state_next = slp_ack ? CG_WAKE : CG_RUN;
                else if (slp_ack) state_next = CG_GATED;
            end
            CG_GATED: begin
                if (wake_req || !cfg_en) state_next = CG_WAKE;
            end
            CG_WAKE: begin
                if ((wake_cnt_reg == WAKE_LAST) && !slp_ack) state_next = CG_RUN;
            end
            default: state_next = CG_RUN;
        endcase
    end

    // Output logic; registered above, so outputs track state_next.
    always_comb begin
        wake_cnt_next = '0;
        if ((state_reg == CG_WAKE) && (state_next == CG_WAKE)) begin
            wake_cnt_next = (wake_cnt_reg == WAKE_LAST) ? wake_cnt_reg
                                                        : wake_cnt_reg + 1'b1;
        end
        ck_en_next     = (state_next != CG_GATED);
        gated_next     = (state_next == CG_GATED);
        slp_req_next   = (state_next == CG_SREQ) || (state_next == CG_GATED) ||
                         ((state_next == CG_WAKE) && (wake_cnt_next != WAKE_LAST));
        wake_done_next = (state_reg == CG_WAKE) && (state_next == CG_RUN);
    end

`ifdef CG_STATS_EN
    logic [CG_STATS_W-1:0] gated_cycles_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cycles_reg <= '0;
        end else if (stats_clr) begin
            gated_cycles_reg <= '0;
        end else if (!ck_en && (gated_cycles_reg != '1)) begin
            gated_cycles_reg <= gated_cycles_reg + 1'b1;
        end
    end

    assign gated_cycles = gated_cycles_reg;
`endif

endmodule
